// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith ops plus iterative MULTU (shift-add)
// and DIVU (restoring), one result bit per clock, with registered outputs.
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [3:0]       aluControl,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] aluResult,
  output logic [WIDTH-1:0] aluResultHi,
  output logic             zero,
  output logic             overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_SLTU  = 4'b0011;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_NOR   = 4'b0101;
  localparam logic [3:0] OP_MULTU = 4'b1000;
  localparam logic [3:0] OP_DIVU  = 4'b1001;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic             is_div_q, is_div_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] res_hi_q, res_hi_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] sum, diff, sc_res;
  logic             sc_ovf;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_sub;
  logic             div_ge;
  logic [WIDTH-1:0] hi_n, lo_n, fin_res, fin_hi;

  // Single-cycle results come straight from the ports on the accepting edge.
  always_comb begin
    sc_res = '0;
    sc_ovf = 1'b0;
    sum    = SrcA + SrcB;
    diff   = SrcA - SrcB;
    case (aluControl)
      OP_AND:  sc_res = SrcA & SrcB;
      OP_OR:   sc_res = SrcA | SrcB;
      OP_ADD: begin
        sc_res = sum;
        sc_ovf = (SrcA[WIDTH-1] == SrcB[WIDTH-1]) && (sum[WIDTH-1] != SrcA[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res = diff;
        sc_ovf = (SrcA[WIDTH-1] != SrcB[WIDTH-1]) && (diff[WIDTH-1] != SrcA[WIDTH-1]);
      end
      OP_SLT:  sc_res[0] = ($signed(SrcA) < $signed(SrcB));
      OP_SLTU: sc_res[0] = (SrcA < SrcB);
      OP_XOR:  sc_res = SrcA ^ SrcB;
      OP_NOR:  sc_res = ~(SrcA | SrcB);
      default: sc_res = '0;
    endcase
  end

  // One iteration step: hi/lo hold partial product or remainder/quotient.
  always_comb begin
    mul_sum   = lo_q[0] ? ({1'b0, hi_q} + {1'b0, a_q}) : {1'b0, hi_q};
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, b_q});
    div_sub   = div_shift[WIDTH-1:0] - b_q;
    if (is_div_q) begin
      hi_n = div_ge ? div_sub : div_shift[WIDTH-1:0];
      lo_n = {lo_q[WIDTH-2:0], div_ge};
    end else begin
      hi_n = mul_sum[WIDTH:1];
      lo_n = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
    if (is_div_q && (b_q == '0)) begin
      fin_res = '1;
      fin_hi  = a_q;
    end else begin
      fin_res = lo_n;
      fin_hi  = hi_n;
    end
  end

  always_comb begin
    state_d  = state_q;
    is_div_d = is_div_q;
    a_d      = a_q;
    b_d      = b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    res_hi_d = res_hi_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          if (aluControl == OP_MULTU || aluControl == OP_DIVU) begin
            state_d  = CALC;
            is_div_d = (aluControl == OP_DIVU);
            a_d      = SrcA;
            b_d      = SrcB;
            hi_d     = '0;
            lo_d     = (aluControl == OP_DIVU) ? SrcA : SrcB;
            cnt_d    = '0;
          end else begin
            state_d  = DONE;
            res_d    = sc_res;
            res_hi_d = '0;
            zero_d   = (sc_res == '0);
            ovf_d    = sc_ovf;
          end
        end
      end
      CALC: begin
        hi_d  = hi_n;
        lo_d  = lo_n;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          state_d  = DONE;
          cnt_d    = '0;
          res_d    = fin_res;
          res_hi_d = fin_hi;
          zero_d   = (fin_res == '0);
          ovf_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      is_div_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      cnt_q    <= '0;
      res_q    <= '0;
      res_hi_q <= '0;
      zero_q   <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      is_div_q <= is_div_d;
      a_q      <= a_d;
      b_q      <= b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
      res_hi_q <= res_hi_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy        = (state_q == CALC);
  assign done        = (state_q == DONE);
  assign aluResult   = res_q;
  assign aluResultHi = res_hi_q;
  assign zero        = zero_q;
  assign overflow    = ovf_q;

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 32, which sets the operand/result width; legal values are 4 to 64.
REQ-002 SHALL use one clock; reset is asynchronous and active-high.
REQ-003 SHALL have port clk, input, 1: rising-edge clock.
REQ-004 SHALL have port rst, input, 1: asynchronous active-high reset.
REQ-005 SHALL have port start, input, 1: request an operation; accepted only when busy=0.
REQ-006 SHALL have port SrcA, input, WIDTH: operand A.
REQ-007 SHALL have port SrcB, input, WIDTH: operand B.
REQ-008 SHALL have port aluControl, input, 4: operation select.
REQ-009 SHALL have port busy, output, 1: multi-cycle operation in progress.
REQ-010 SHALL have port done, output, 1: one-cycle pulse, results valid.
REQ-011 SHALL have port aluResult, output, WIDTH: main result (low product / quotient).
REQ-012 SHALL have port aluResultHi, output, WIDTH: high product / remainder; 0 for all other operations.
REQ-013 SHALL have port zero, output, 1: set when aluResult==0.
REQ-014 SHALL have port overflow, output, 1: signed overflow on ADD/SUB; 0 otherwise.

Function
REQ-015 SHALL decode aluControl as follows:
- 0000 AND
- 0001 OR
- 0010 ADD
- 0110 SUB
- 0111 SLT (signed)
- 0011 SLTU
- 0100 XOR
- 0101 NOR
- 1000 MULTU
- 1001 DIVU
- any other code: result 0, single-cycle
REQ-016 SHALL latch SrcA, SrcB and aluControl on the clk edge where start=1 and busy=0; input changes after that edge have no effect.
REQ-017 SHALL ignore start while busy=1, with no state change and no error.
REQ-018 SHALL implement three states:
- IDLE: done=0, busy=0.
- CALC: busy=1.
- DONE: done=1 for exactly one cycle, busy=0.
REQ-019 SHALL make these state transitions:
- IDLE/DONE + accepted single-cycle op -> DONE.
- IDLE/DONE + accepted MULTU/DIVU -> CALC.
- CALC with iteration count = WIDTH-1 -> DONE.
- DONE without start -> IDLE.
REQ-020 SHALL produce results with these latencies, where the start edge is cycle t:
- Single-cycle ops: done=1 in cycle t+1.
- MULTU/DIVU: busy=1 in cycles t+1..t+WIDTH, done=1 in cycle t+WIDTH+1.
REQ-021 SHALL accept start while in DONE, giving back-to-back operation with no idle bubble.
REQ-022 SHALL implement MULTU as an unsigned shift-add over WIDTH iterations, one bit per cycle; {aluResultHi, aluResult} = full 2*WIDTH product.
REQ-023 SHALL implement DIVU as a restoring unsigned division over WIDTH iterations, one bit per cycle; aluResult = quotient, aluResultHi = remainder.
REQ-024 SHALL handle DIVU with SrcB=0 as follows: aluResult = all ones, aluResultHi = SrcA, same latency, no other flag.
REQ-025 SHALL compute ADD/SUB modulo 2^WIDTH, with overflow = (operand signs make a same-sign sum) and (result sign differs).
REQ-026 SHALL return SLT/SLTU results as 1 or 0, zero-extended to WIDTH.
REQ-027 SHALL register aluResult, aluResultHi, zero and overflow, update them only on the edge entering DONE, and hold them stable until the next completion.
REQ-028 SHALL keep intermediate CALC values off the output ports.

Reset
REQ-029 SHALL, on rst=1 and without waiting for a clock edge, force state IDLE, busy=0, done=0, aluResult=0, aluResultHi=0, zero=1, overflow=0, and clear the iteration counter.
REQ-030 SHALL abort an operation in progress when rst is asserted mid-CALC, with no done pulse after release.
REQ-031 SHALL accept start on the first clk edge after rst deasserts.

Verification (WIDTH=32)
REQ-032 SHALL pass the ADD overflow case: ADD 0x7FFFFFFF + 0x00000001 -> cycle t+1: done=1, aluResult=0x80000000, overflow=1, zero=0.
REQ-033 SHALL pass the SUB/SLT/SLTU cases:
- SUB 5-5 -> aluResult=0, zero=1, overflow=0.
- SLT 0xFFFFFFFF vs 1 -> 1.
- SLTU same operands -> 0.
REQ-034 SHALL pass the MULTU case: MULTU 0xFFFFFFFF x 0xFFFFFFFF -> busy=1 for 32 cycles; at cycle t+33 done=1, aluResultHi=0xFFFFFFFE, aluResult=0x00000001.
REQ-035 SHALL pass the DIVU cases:
- DIVU 100/7 -> aluResult=14, aluResultHi=2 at cycle t+33.
- DIVU 5/0 -> aluResult=0xFFFFFFFF, aluResultHi=5.
REQ-036 SHALL pass the start-during-busy case: start pulsed with ADD mid-MULTU and operands changed -> ignored; the MULTU result is unaffected; exactly one done pulse.
REQ-037 SHALL pass the reset and back-to-back cases:
- rst at cycle t+10 of a DIVU -> immediate busy=0, outputs zeroed, no done.
- ADD issued in the DONE cycle of a prior op -> done again in the following cycle.
